// File: rtl/gps_pps_tod_tx.sv
// Emulated GPS receiver: 1 Hz PPS pulse plus a 5-byte UART time-of-day frame
// (A5, hour, minute, second, checksum) launched on every second boundary.
module gps_pps_tod_tx #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int PPS_WIDTH = 10_000_000,
    parameter int BAUD_DIV  = 868
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        wr,
    input  logic [31:0] hourInit,
    input  logic [31:0] minuteInit,
    input  logic [31:0] secondInit,
    output logic        pps_out,
    output logic        tx_out,
    output logic        tx_busy,
    output logic        frame_done,
    output logic        frame_skip,
    output logic [31:0] second_out,
    output logic [31:0] minute_out,
    output logic [31:0] hour_out
);

    localparam logic [31:0] CNT_MAX  = 32'(CLK_HZ - 1);
    localparam logic [31:0] PPS_MAX  = 32'(PPS_WIDTH - 1);
    localparam logic [31:0] BAUD_MAX = 32'(BAUD_DIV - 1);
    localparam logic [7:0]  SYNC     = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // Frame checksum: XOR over the three time fields
    function automatic logic [7:0] tod_checksum(input logic [7:0] h, input logic [7:0] m,
                                                input logic [7:0] s);
        return h ^ m ^ s;
    endfunction

    uart_state_t state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] pps_cnt_q, pps_cnt_d;
    logic [31:0] baud_q, baud_d;
    logic [5:0]  sec_q, sec_d, min_q, min_d;
    logic [4:0]  hour_q, hour_d;
    logic [2:0]  bit_q, bit_d, byte_q, byte_d;
    logic [7:0]  shift_q, shift_d;
    logic [31:0] frame_q, frame_d;   // remaining bytes: {chk, sec, min, hour}
    logic        pps_q, pps_d, tx_q, tx_d, busy_q, busy_d, done_q, done_d, skip_q, skip_d;

    logic        wrap_s, bit_end_s;
    logic [5:0]  inc_sec_s, inc_min_s;
    logic [4:0]  inc_hour_s;
    logic [7:0]  f_hour_s, f_min_s, f_sec_s;

    // Second boundary and end-of-bit strobes
    always_comb begin
        wrap_s    = enable && (cnt_q == CNT_MAX);
        bit_end_s = (baud_q == BAUD_MAX);
    end

    // Time of day one second ahead, with minute/hour/day carries
    always_comb begin
        if (sec_q == 6'd59) begin
            inc_sec_s = 6'd0;
            if (min_q == 6'd59) begin
                inc_min_s = 6'd0;
                if (hour_q == 5'd23) begin
                    inc_hour_s = 5'd0;
                end else begin
                    inc_hour_s = hour_q + 5'd1;
                end
            end else begin
                inc_min_s  = min_q + 6'd1;
                inc_hour_s = hour_q;
            end
        end else begin
            inc_sec_s  = sec_q + 6'd1;
            inc_min_s  = min_q;
            inc_hour_s = hour_q;
        end
        f_hour_s = {3'd0, inc_hour_s};
        f_min_s  = {2'd0, inc_min_s};
        f_sec_s  = {2'd0, inc_sec_s};
    end

    // Next-state logic: wr load/abort, second counter, PPS, time, UART framer
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pps_cnt_d = pps_cnt_q;
        baud_d    = baud_q;
        sec_d     = sec_q;
        min_d     = min_q;
        hour_d    = hour_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        frame_d   = frame_q;
        pps_d     = pps_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        skip_d    = 1'b0;

        if (wr) begin
            // Out-of-range init fields load as zero
            hour_d    = (hourInit   < 32'd24) ? hourInit[4:0]   : 5'd0;
            min_d     = (minuteInit < 32'd60) ? minuteInit[5:0] : 6'd0;
            sec_d     = (secondInit < 32'd60) ? secondInit[5:0] : 6'd0;
            cnt_d     = 32'd0;
            pps_d     = 1'b0;
            pps_cnt_d = 32'd0;
            state_d   = ST_IDLE;
            baud_d    = 32'd0;
            bit_d     = 3'd0;
            byte_d    = 3'd0;
            tx_d      = 1'b1;
            busy_d    = 1'b0;
        end else begin
            if (enable) begin
                cnt_d = (cnt_q == CNT_MAX) ? 32'd0 : cnt_q + 32'd1;
            end else begin
                cnt_d = cnt_q;
            end

            // PPS width is counted in raw clocks so it ignores enable
            if (wrap_s) begin
                pps_d     = 1'b1;
                pps_cnt_d = 32'd0;
            end else if (pps_q) begin
                if (pps_cnt_q == PPS_MAX) begin
                    pps_d     = 1'b0;
                    pps_cnt_d = 32'd0;
                end else begin
                    pps_cnt_d = pps_cnt_q + 32'd1;
                end
            end else begin
                pps_d = 1'b0;
            end

            if (wrap_s) begin
                sec_d  = inc_sec_s;
                min_d  = inc_min_s;
                hour_d = inc_hour_s;
            end else begin
                sec_d  = sec_q;
            end

            // A second that wraps under a running frame is announced, not sent
            if (wrap_s && (state_q != ST_IDLE)) begin
                skip_d = 1'b1;
            end else begin
                skip_d = 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (wrap_s) begin
                        state_d = ST_START;
                        tx_d    = 1'b0;
                        busy_d  = 1'b1;
                        baud_d  = 32'd0;
                        bit_d   = 3'd0;
                        byte_d  = 3'd0;
                        shift_d = SYNC;
                        frame_d = {tod_checksum(f_hour_s, f_min_s, f_sec_s),
                                   f_sec_s, f_min_s, f_hour_s};
                    end else begin
                        tx_d = 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_d = ST_DATA;
                        baud_d  = 32'd0;
                        bit_d   = 3'd0;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end else begin
                        baud_d = baud_q + 32'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        baud_d = 32'd0;
                        if (bit_q == 3'd7) begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            tx_d    = shift_q[0];
                            shift_d = {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        baud_d = baud_q + 32'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        baud_d = 32'd0;
                        if (byte_q == 3'd4) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_START;
                            tx_d    = 1'b0;
                            byte_d  = byte_q + 3'd1;
                            shift_d = frame_q[7:0];
                            frame_d = {8'd0, frame_q[31:8]};
                        end
                    end else begin
                        baud_d = baud_q + 32'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State register with asynchronous reset to idle / line high
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 32'd0;
            pps_cnt_q <= 32'd0;
            baud_q    <= 32'd0;
            sec_q     <= 6'd0;
            min_q     <= 6'd0;
            hour_q    <= 5'd0;
            bit_q     <= 3'd0;
            byte_q    <= 3'd0;
            shift_q   <= 8'd0;
            frame_q   <= 32'd0;
            pps_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            skip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pps_cnt_q <= pps_cnt_d;
            baud_q    <= baud_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            shift_q   <= shift_d;
            frame_q   <= frame_d;
            pps_q     <= pps_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            skip_q    <= skip_d;
        end
    end

    assign pps_out    = pps_q;
    assign tx_out     = tx_q;
    assign tx_busy    = busy_q;
    assign frame_done = done_q;
    assign frame_skip = skip_q;
    assign second_out = {26'd0, sec_q};
    assign minute_out = {26'd0, min_q};
    assign hour_out   = {27'd0, hour_q};

endmodule

// File: tb/tb_gps_pps_tod_tx.sv
// Bench for gps_pps_tod_tx: two instances (fast and slow baud), time kept as
// seconds-of-day in the bench, UART frames decoded by mid-bit sampling.
module tb_gps_pps_tod_tx;

    localparam int CLK_HZ    = 1000;
    localparam int PPS_WIDTH = 100;
    localparam int BAUD_A    = 4;
    localparam int BAUD_B    = 30;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        enable_a = 1'b0, wr_a = 1'b0, enable_b = 1'b0, wr_b = 1'b0;
    logic [31:0] hour_init = 32'd0, minute_init = 32'd0, second_init = 32'd0;
    logic        pps_a, tx_a, busy_a, done_a, skip_a;
    logic        pps_b, tx_b, busy_b, done_b, skip_b;
    logic [31:0] sec_a, min_a, hour_a, sec_b, min_b, hour_b;

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;
    int done_a_cnt = 0, skip_a_cnt = 0, skip_b_cnt = 0, skip_b_cyc = -1;

    gps_pps_tod_tx #(.CLK_HZ(CLK_HZ), .PPS_WIDTH(PPS_WIDTH), .BAUD_DIV(BAUD_A)) dut_a (
        .clk(clk), .resetn(resetn), .enable(enable_a), .wr(wr_a),
        .hourInit(hour_init), .minuteInit(minute_init), .secondInit(second_init),
        .pps_out(pps_a), .tx_out(tx_a), .tx_busy(busy_a), .frame_done(done_a),
        .frame_skip(skip_a), .second_out(sec_a), .minute_out(min_a), .hour_out(hour_a));

    gps_pps_tod_tx #(.CLK_HZ(CLK_HZ), .PPS_WIDTH(PPS_WIDTH), .BAUD_DIV(BAUD_B)) dut_b (
        .clk(clk), .resetn(resetn), .enable(enable_b), .wr(wr_b),
        .hourInit(hour_init), .minuteInit(minute_init), .secondInit(second_init),
        .pps_out(pps_b), .tx_out(tx_b), .tx_busy(busy_b), .frame_done(done_b),
        .frame_skip(skip_b), .second_out(sec_b), .minute_out(min_b), .hour_out(hour_b));

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (done_a === 1'b1) done_a_cnt++;
        if (skip_a === 1'b1) skip_a_cnt++;
        if (skip_b === 1'b1) begin
            skip_b_cnt++;
            skip_b_cyc = cyc_cnt;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model helpers ----------------
    function automatic int tod_load(input logic [31:0] h, input logic [31:0] m, input logic [31:0] s);
        int hh = (h < 32'd24) ? int'(h) : 0;
        int mm = (m < 32'd60) ? int'(m) : 0;
        int ss = (s < 32'd60) ? int'(s) : 0;
        return hh * 3600 + mm * 60 + ss;
    endfunction

    function automatic logic [7:0] exp_byte(input int tod, input int k);
        logic [7:0] h = 8'(tod / 3600);
        logic [7:0] m = 8'((tod / 60) % 60);
        logic [7:0] s = 8'(tod % 60);
        case (k)
            0:       return 8'hA5;
            1:       return h;
            2:       return m;
            3:       return s;
            default: return h ^ m ^ s;
        endcase
    endfunction

    function automatic logic tx_of(input bit sel);
        return sel ? tx_b : tx_a;
    endfunction

    function automatic logic pps_of(input bit sel);
        return sel ? pps_b : pps_a;
    endfunction

    // ---------------- checking / stimulus tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag, input bit sel, input int tod);
        check({tag, "_hour"}, sel ? hour_b : hour_a, 32'(tod / 3600));
        check({tag, "_min"},  sel ? min_b  : min_a,  32'((tod / 60) % 60));
        check({tag, "_sec"},  sel ? sec_b  : sec_a,  32'(tod % 60));
    endtask

    // Waits for PPS to be seen high; n = negedges waited (bounded)
    task automatic wait_pps(input bit sel, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pps_of(sel) !== 1'b1 && n < limit);
    endtask

    task automatic do_wr_a(input logic [31:0] h, input logic [31:0] m, input logic [31:0] s,
                           output int tod);
        hour_init = h; minute_init = m; second_init = s;
        wr_a = 1'b1;
        @(negedge clk);
        wr_a = 1'b0;
        tod = tod_load(h, m, s);
    endtask

    // Entry: first negedge of a start bit. Exit: stop-bit mid sample.
    task automatic rx_byte(input bit sel, input int baud, output logic [7:0] b);
        int half = baud / 2;
        repeat (half) @(negedge clk);
        check("start_bit", 32'(tx_of(sel)), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (baud) @(negedge clk);
            b[i] = tx_of(sel);
        end
        repeat (baud) @(negedge clk);
        check("stop_bit", 32'(tx_of(sel)), 32'd1);
    endtask

    task automatic rx_frame(input string tag, input bit sel, input int baud, input int tod);
        logic [7:0] b;
        for (int k = 0; k < 5; k++) begin
            rx_byte(sel, baud, b);
            check({tag, "_byte"}, 32'(b), 32'(exp_byte(tod, k)));
            if (k == 4) begin
                check({tag, "_busy_last"}, 32'(sel ? busy_b : busy_a), 32'd1);
                check({tag, "_done_early"}, 32'(sel ? done_b : done_a), 32'd0);
            end
            repeat (baud - baud / 2) @(negedge clk);
        end
        check({tag, "_busy_end"}, 32'(sel ? busy_b : busy_a), 32'd0);
        check({tag, "_done"}, 32'(sel ? done_b : done_a), 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(sel ? done_b : done_a), 32'd0);
    endtask

    // ---------------- directed + randomized sequence ----------------
    initial begin
        int n;
        int tod_a = 0;
        int tod_b = 0;
        int w1, done_snap;
        logic [7:0] b;
        logic [31:0] rh, rm, rs;

        // reset state
        enable_a = 1'b1;
        #1 resetn = 1'b0;
        #1;
        check("rst_pps", 32'(pps_a), 32'd0);
        check("rst_tx", 32'(tx_a), 32'd1);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done_skip", {30'd0, done_a, skip_a}, 32'd0);
        check_time("rst", 1'b0, 0);
        @(negedge clk);
        resetn = 1'b1;

        // first PPS 1000 cycles after release; width 100 even with enable low
        wait_pps(1'b0, 3000, n);
        check("t1_pps_rise", 32'(n), 32'd1000);
        tod_a = 1;
        check_time("t1", 1'b0, tod_a);
        enable_a = 1'b0;
        n = 0;
        while (pps_a === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("t1_pps_width", 32'(n), 32'd100);
        enable_a = 1'b1;
        repeat (150) @(negedge clk);

        // day rollover and a known frame
        do_wr_a(32'd23, 32'd59, 32'd59, tod_a);
        wait_pps(1'b0, 3000, n);
        check("t2_wrap_dly", 32'(n), 32'd1000);
        tod_a = (tod_a + 1) % 86400;
        check_time("t2", 1'b0, tod_a);
        rx_frame("t2", 1'b0, BAUD_A, tod_a);

        do_wr_a(32'd12, 32'd34, 32'd56, tod_a);
        wait_pps(1'b0, 3000, n);
        check("t3_wrap_dly", 32'(n), 32'd1000);
        tod_a = (tod_a + 1) % 86400;
        rx_frame("t3", 1'b0, BAUD_A, tod_a);

        // random loads, last one with out-of-range fields
        for (int it = 0; it < 3; it++) begin
            rh = $urandom_range(0, 23);
            rm = $urandom_range(0, 59);
            rs = $urandom_range(0, 59);
            if (it == 2) begin
                rh = $urandom_range(24, 1000);
                rm = $urandom_range(60, 255);
            end
            do_wr_a(rh, rm, rs, tod_a);
            check_time("rnd_load", 1'b0, tod_a);
            wait_pps(1'b0, 3000, n);
            check("rnd_wrap_dly", 32'(n), 32'd1000);
            tod_a = (tod_a + 1) % 86400;
            check_time("rnd", 1'b0, tod_a);
            rx_frame("rnd", 1'b0, BAUD_A, tod_a);
        end

        // wr in the middle of byte 2 aborts the frame
        do_wr_a($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59), tod_a);
        wait_pps(1'b0, 3000, n);
        tod_a = (tod_a + 1) % 86400;
        rx_byte(1'b0, BAUD_A, b);
        repeat (BAUD_A - BAUD_A / 2) @(negedge clk);
        rx_byte(1'b0, BAUD_A, b);
        check("t4_byte1", 32'(b), 32'(exp_byte(tod_a, 1)));
        repeat (BAUD_A - BAUD_A / 2 + 10) @(negedge clk);
        done_snap = done_a_cnt;
        hour_init = $urandom_range(0, 23);
        minute_init = $urandom_range(0, 59);
        second_init = $urandom_range(0, 59);
        wr_a = 1'b1;
        @(negedge clk);
        wr_a = 1'b0;
        tod_a = tod_load(hour_init, minute_init, second_init);
        check("t4_tx_idle", 32'(tx_a), 32'd1);
        check("t4_busy", 32'(busy_a), 32'd0);
        check("t4_pps", 32'(pps_a), 32'd0);
        check_time("t4", 1'b0, tod_a);
        repeat (300) @(negedge clk);
        check("t4_no_done", 32'(done_a_cnt), 32'(done_snap));
        check("t4_tx_stays", 32'(tx_a), 32'd1);
        wait_pps(1'b0, 3000, n);
        check("t4_next_wrap", 32'(n), 32'd700);

        // slow baud: second wrap lands inside the first frame
        hour_init = $urandom_range(0, 23);
        minute_init = $urandom_range(0, 59);
        second_init = $urandom_range(0, 59);
        wr_b = 1'b1;
        enable_b = 1'b1;
        @(negedge clk);
        wr_b = 1'b0;
        tod_b = tod_load(hour_init, minute_init, second_init);
        wait_pps(1'b1, 3000, n);
        check("t5_wrap_dly", 32'(n), 32'd1000);
        w1 = cyc_cnt;
        tod_b = (tod_b + 1) % 86400;
        check_time("t5_first", 1'b1, tod_b);
        rx_frame("t5", 1'b1, BAUD_B, tod_b);
        check("t5_skip_cnt", 32'(skip_b_cnt), 32'd1);
        check("t5_skip_at", 32'(skip_b_cyc), 32'(w1 + CLK_HZ));
        check_time("t5_second", 1'b1, (tod_b + 1) % 86400);
        repeat (10) @(negedge clk);
        check("t5_no_new_frame", {30'd0, busy_b, tx_b}, 32'd1);
        enable_b = 1'b0;

        // enable held low for 200 cycles delays the PPS by 200
        do_wr_a($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59), tod_a);
        repeat (300) @(negedge clk);
        enable_a = 1'b0;
        repeat (200) @(negedge clk);
        enable_a = 1'b1;
        wait_pps(1'b0, 3000, n);
        check("t6_late_pps", 32'(n), 32'd700);
        tod_a = (tod_a + 1) % 86400;
        check_time("t6", 1'b0, tod_a);

        // asynchronous reset in the middle of the pulse and frame
        repeat (50) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("t6_rst_pps", 32'(pps_a), 32'd0);
        check("t6_rst_tx", 32'(tx_a), 32'd1);
        check("t6_rst_busy", 32'(busy_a), 32'd0);
        check_time("t6_rst", 1'b0, 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        check("no_skip_fast", 32'(skip_a_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
